rect_fill_writer: RTL and testbench
===================================

RECT_FILL_WRITER -- requirements
Module: rect_fill_writer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  system clock
  reset  in  1  synchronous reset, active-high
  start  in  1  request a rectangle fill; sampled only in IDLE
  x0  in  10  left column
  y0  in  9  top row
  x1  in  10  right column, inclusive
  y1  in  9  bottom row, inclusive
  color  in  3  fill color
  full  in  1  draw-unit FIFO full; no word may be written while high
  we  out  1  FIFO write strobe
  data  out  22  pixel word {color[2:0], y[8:0], x[9:0]} (bits 21:19, 18:10, 9:0)
  busy  out  1  high in EMIT and DONE
  done  out  1  one-cycle pulse at command completion
  err  out  1  valid with done; command rejected
  pix_count  out  19  words written for the current command

Function
REQ-003 The FSM SHALL have three states: IDLE, EMIT, DONE.
REQ-004 In IDLE with start=1, the block SHALL register x0, y0, x1, y1 and color, and SHALL clear pix_count.
REQ-005 On that same edge, the FSM SHALL go to EMIT with cur_x=x0 and cur_y=y0 if the parameters are legal.
REQ-006 The parameters SHALL be legal only when x0<=x1, y0<=y1, x1<=639 and y1<=479.
REQ-007 For illegal parameters, the FSM SHALL go directly to DONE with err flagged, and SHALL write no words.
REQ-008 In EMIT, we SHALL be combinational: we = !full && !reset.
REQ-009 data SHALL always present {color_r, cur_y, cur_x} from registers.
REQ-010 A word SHALL count as written on every edge where we=1; there SHALL be no other acceptance handshake.
REQ-011 On each written word, pix_count SHALL increment by 1.
REQ-012 On each written word, if cur_x<x1_r then cur_x SHALL increment.
REQ-013 Otherwise, if cur_y<y1_r, then cur_x SHALL return to x0_r and cur_y SHALL increment (row-major order).
REQ-014 Otherwise, the word at (x1_r, y1_r) is the last word, and the FSM SHALL go to DONE.
REQ-015 While full=1 in EMIT, we SHALL be 0, and cur_x, cur_y and pix_count SHALL hold; a stall of any length SHALL be allowed.
REQ-016 Latency: with start sampled at edge N and full=0, the first we SHALL be high in the cycle following edge N.
REQ-017 With full=0 throughout, a W×H rectangle SHALL produce exactly W*H consecutive we cycles.
REQ-018 DONE SHALL last exactly one cycle, during which done=1 and err reflects the command; the FSM SHALL then return to IDLE.
REQ-019 start SHALL be ignored in EMIT and DONE; a start in DONE SHALL NOT be queued.
REQ-020 A start in IDLE during the cycle after DONE SHALL be accepted.
REQ-021 Outside EMIT, we SHALL be 0; done and err SHALL be 0 outside DONE.
REQ-022 pix_count SHALL hold its final value after DONE until the next accepted start.
REQ-023 The maximum command size SHALL be 640*480 = 307200 words, which fits in 19 bits; pix_count SHALL NOT wrap.
REQ-024 busy SHALL be 1 in EMIT and DONE, and 0 in IDLE.

Reset
REQ-025 With reset=1 at an edge, the FSM SHALL go to IDLE from any state, including mid-EMIT; the aborted command SHALL be discarded with no done pulse.
REQ-026 After reset, outputs SHALL be: we=0, busy=0, done=0, err=0, pix_count=0, data=0.
REQ-027 All internal registers (cur_x, cur_y, x0_r, y0_r, x1_r, y1_r, color_r) SHALL be 0 after reset.
REQ-028 we SHALL be 0 during any cycle in which reset=1, regardless of state.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
  - 2x2 fill: x0=5, y0=3, x1=6, y1=4, color=3'b101, full=0 -> 4 consecutive we cycles with data = {101,3,5}, {101,3,6}, {101,4,5}, {101,4,6}; then done=1, err=0, pix_count=4.
  - Backpressure: same 2x2 command with full=1 for 3 cycles after the 2nd word -> we=0 for those 3 cycles, the 3rd word is still {101,4,5}, the total is still 4 words, and done is delayed by 3 cycles.
  - Single pixel: x0=x1=639, y0=y1=479 -> exactly 1 we with data {color,479,639}; next cycle done=1.
  - Illegal: x0=10, x1=9 (and separately x1=640) -> no we; done=1, err=1 one cycle after start; pix_count=0.
  - Reset mid-EMIT after 2 of 4 words -> we=0 in the reset cycle, busy=0 after it, no done pulse; a new start then runs cleanly from pix_count=0.
  - start pulsed during EMIT with different coordinates -> ignored; the original rectangle completes unchanged.

Source files
------------

// File: rtl/rect_fill_writer.sv
// Rectangle fill command unit: streams one pixel word per cycle into a draw-unit FIFO
// in row-major order, stalling on FIFO full, and reports completion/rejection.
module rect_fill_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  x0,
    input  logic [8:0]  y0,
    input  logic [9:0]  x1,
    input  logic [8:0]  y1,
    input  logic [2:0]  color,
    input  logic        full,
    output logic        we,
    output logic [21:0] data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [18:0] pix_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [9:0]  cur_x_q;
    logic [8:0]  cur_y_q;
    logic [9:0]  x0_q;
    logic [8:0]  y0_q;
    logic [9:0]  x1_q;
    logic [8:0]  y1_q;
    logic [2:0]  color_q;
    logic [18:0] pix_count_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        legal;

    always_comb begin
        legal = (x0 <= x1) && (y0 <= y1) && (x1 <= 10'd639) && (y1 <= 9'd479);
    end

    // Write strobe is the only acceptance condition, so it must drop during reset.
    assign we        = (state_q == EMIT) && !full && !reset;
    assign data      = {color_q, cur_y_q, cur_x_q};
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pix_count = pix_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            pix_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x0_q        <= x0;
                        y0_q        <= y0;
                        x1_q        <= x1;
                        y1_q        <= y1;
                        color_q     <= color;
                        cur_x_q     <= x0;
                        cur_y_q     <= y0;
                        pix_count_q <= '0;
                        busy_q      <= 1'b1;
                        if (legal) begin
                            state_q <= EMIT;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (!full) begin
                        pix_count_q <= pix_count_q + 19'd1;
                        if (cur_x_q < x1_q) begin
                            cur_x_q <= cur_x_q + 10'd1;
                        end else if (cur_y_q < y1_q) begin
                            cur_x_q <= x0_q;
                            cur_y_q <= cur_y_q + 9'd1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Self-checking bench for rect_fill_writer: directed scenarios plus randomized
// back-to-back commands against a nested-loop rectangle model.
module tb_rect_fill_writer;

    logic        clk = 1'b0;
    logic        reset, start, full;
    logic [9:0]  x0, x1;
    logic [8:0]  y0, y1;
    logic [2:0]  color;
    logic        we, busy, done, err;
    logic [21:0] data;
    logic [18:0] pix_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [21:0] got_q[$];
    logic [21:0] exp_q[$];
    int          done_c, stalls, we_full, busy_low;
    logic        err_at;
    logic        exp_legal;

    always #5 clk = ~clk;

    rect_fill_writer dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .full(full), .we(we), .data(data), .busy(busy),
        .done(done), .err(err), .pix_count(pix_count)
    );

    // Reference: the rectangle as a row-major list of words, empty if rejected.
    function automatic void build_expected(input int ax0, input int ay0, input int ax1,
                                           input int ay1, input logic [2:0] c);
        exp_q.delete();
        exp_legal = (ax0 <= ax1) && (ay0 <= ay1) && (ax1 <= 639) && (ay1 <= 479);
        if (exp_legal)
            for (int y = ay0; y <= ay1; y++)
                for (int x = ax0; x <= ax1; x++)
                    exp_q.push_back({c, 9'(y), 10'(x)});
    endfunction

    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1,
                         input logic [2:0] c);
        @(negedge clk);
        x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1); color = c;
        full = 1'b0; start = 1'b1;
        build_expected(ax0, ay0, ax1, ay1, c);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes one command from the cycle after start until done (or budget expiry).
    // mode 0: no stall, 1: random full, 2: 3-cycle full after 2nd word, 3: start spam.
    task automatic collect(input int mode, input int budget);
        int stall_left;
        stall_left = 3;
        got_q.delete();
        done_c = -1; stalls = 0; we_full = 0; busy_low = 0; err_at = 1'b0;
        for (int c = 0; c < budget; c++) begin
            case (mode)
                1: full = ($urandom_range(0, 3) == 0);
                2: begin
                    full = (got_q.size() == 2) && (stall_left > 0);
                    if (full) stall_left--;
                end
                3: begin
                    full = 1'b0;
                    if (c >= 1) begin
                        start = 1'b1;
                        x0 = 10'd100; y0 = 9'd100; x1 = 10'd101; y1 = 9'd101; color = 3'd2;
                    end
                end
                default: full = 1'b0;
            endcase
            #1;
            if (we) got_q.push_back(data);
            if (we && full) we_full++;
            if (!busy) busy_low++;
            if (done) begin
                done_c = c;
                err_at = err;
                break;
            end
            if (full) stalls++;
            @(negedge clk);
        end
        full = 1'b0;
    endtask

    task automatic check_words(input string tag);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s word_count got=%0d exp=%0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s word[%0d] got=%h exp=%h", tag, i,
                         (i < got_q.size()) ? got_q[i] : 22'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; full = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL rst_we_during got=%b exp=0", we); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%b exp=0", we); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
        n_cmp++; if (pix_count !== 19'd0) begin n_fail++; $display("FAIL rst_pix got=%0d exp=0", pix_count); end
        n_cmp++; if (data !== 22'd0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", data); end
    endtask

    task automatic test_fill_2x2;
        logic [21:0] w0;
        w0 = {3'b101, 9'd3, 10'd5};
        issue(5, 3, 6, 4, 3'b101);
        collect(0, 30);
        check_words("fill2x2");
        n_cmp++; if (got_q.size() < 1 || got_q[0] !== w0) begin n_fail++; $display("FAIL fill2x2_first got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : 22'h0, w0); end
        n_cmp++; if (done_c !== 4) begin n_fail++; $display("FAIL fill2x2_done_cycle got=%0d exp=4", done_c); end
        n_cmp++; if (err_at !== 1'b0) begin n_fail++; $display("FAIL fill2x2_err got=%b exp=0", err_at); end
        n_cmp++; if (pix_count !== 19'd4) begin n_fail++; $display("FAIL fill2x2_pix got=%0d exp=4", pix_count); end
        n_cmp++; if (busy_low !== 0) begin n_fail++; $display("FAIL fill2x2_busy_low got=%0d exp=0", busy_low); end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill2x2_idle_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL fill2x2_done_pulse got=%b exp=0", done); end
        n_cmp++; if (pix_count !== 19'd4) begin n_fail++; $display("FAIL fill2x2_pix_hold got=%0d exp=4", pix_count); end
    endtask

    task automatic test_backpressure;
        logic [21:0] w2;
        w2 = {3'b101, 9'd4, 10'd5};
        issue(5, 3, 6, 4, 3'b101);
        collect(2, 40);
        check_words("bp");
        n_cmp++; if (got_q.size() < 3 || got_q[2] !== w2) begin n_fail++; $display("FAIL bp_third got=%h exp=%h", (got_q.size() > 2) ? got_q[2] : 22'h0, w2); end
        n_cmp++; if (we_full !== 0) begin n_fail++; $display("FAIL bp_we_while_full got=%0d exp=0", we_full); end
        n_cmp++; if (stalls !== 3) begin n_fail++; $display("FAIL bp_stalls got=%0d exp=3", stalls); end
        n_cmp++; if (done_c !== 7) begin n_fail++; $display("FAIL bp_done_cycle got=%0d exp=7", done_c); end
        n_cmp++; if (pix_count !== 19'd4) begin n_fail++; $display("FAIL bp_pix got=%0d exp=4", pix_count); end
    endtask

    task automatic test_single_and_row;
        logic [21:0] w0;
        w0 = {3'b011, 9'd479, 10'd639};
        issue(639, 479, 639, 479, 3'b011);
        collect(0, 10);
        check_words("single");
        n_cmp++; if (got_q.size() < 1 || got_q[0] !== w0) begin n_fail++; $display("FAIL single_word got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : 22'h0, w0); end
        n_cmp++; if (done_c !== 1) begin n_fail++; $display("FAIL single_done_cycle got=%0d exp=1", done_c); end
        n_cmp++; if (err_at !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b exp=0", err_at); end
        issue(0, 479, 639, 479, 3'b110);
        collect(0, 700);
        check_words("row");
        n_cmp++; if (done_c !== 640) begin n_fail++; $display("FAIL row_done_cycle got=%0d exp=640", done_c); end
        n_cmp++; if (pix_count !== 19'd640) begin n_fail++; $display("FAIL row_pix got=%0d exp=640", pix_count); end
    endtask

    task automatic test_illegal;
        int cases[2][4] = '{'{10, 0, 9, 0}, '{0, 0, 640, 0}};
        for (int k = 0; k < 2; k++) begin
            issue(cases[k][0], cases[k][1], cases[k][2], cases[k][3], 3'b111);
            collect(0, 10);
            n_cmp++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL illegal%0d_words got=%0d exp=0", k, got_q.size()); end
            n_cmp++; if (done_c !== 0) begin n_fail++; $display("FAIL illegal%0d_done_cycle got=%0d exp=0", k, done_c); end
            n_cmp++; if (err_at !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_err got=%b exp=1", k, err_at); end
            n_cmp++; if (pix_count !== 19'd0) begin n_fail++; $display("FAIL illegal%0d_pix got=%0d exp=0", k, pix_count); end
        end
    endtask

    task automatic test_reset_mid;
        int words, pulses;
        words = 0; pulses = 0;
        issue(5, 3, 6, 4, 3'b101);
        for (int c = 0; c < 2; c++) begin
            #1;
            if (we) words++;
            @(negedge clk);
        end
        n_cmp++; if (words !== 2) begin n_fail++; $display("FAIL rmid_pre_words got=%0d exp=2", words); end
        reset = 1'b1;
        #1;
        n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL rmid_we_in_reset got=%b exp=0", we); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        n_cmp++; if (pix_count !== 19'd0) begin n_fail++; $display("FAIL rmid_pix got=%0d exp=0", pix_count); end
        for (int c = 0; c < 6; c++) begin
            if (done) pulses++;
            @(negedge clk); #1;
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rmid_done_pulses got=%0d exp=0", pulses); end
        issue(5, 3, 6, 4, 3'b101);
        collect(0, 30);
        check_words("rmid_rerun");
        n_cmp++; if (done_c !== 4) begin n_fail++; $display("FAIL rmid_rerun_done got=%0d exp=4", done_c); end
        n_cmp++; if (pix_count !== 19'd4) begin n_fail++; $display("FAIL rmid_rerun_pix got=%0d exp=4", pix_count); end
    endtask

    task automatic test_start_ignored;
        issue(5, 3, 6, 4, 3'b101);
        collect(3, 30);
        check_words("ignore");
        n_cmp++; if (done_c !== 4) begin n_fail++; $display("FAIL ignore_done_cycle got=%0d exp=4", done_c); end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_queued_busy got=%b exp=0", busy); end
        n_cmp++; if (pix_count !== 19'd4) begin n_fail++; $display("FAIL ignore_pix got=%0d exp=4", pix_count); end
    endtask

    task automatic test_back_to_back;
        int ax0, ay0, ax1, ay1, w, h, k;
        for (int n = 0; n < 25; n++) begin
            k = $urandom_range(0, 5);
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            ax0 = $urandom_range(0, 640 - w);
            ay0 = $urandom_range(0, 480 - h);
            ax1 = ax0 + w - 1;
            ay1 = ay0 + h - 1;
            if (k == 0) begin ax0 = ax0 + 1; ax1 = ax0 - 1; end
            else if (k == 1) ax1 = 640 + $urandom_range(0, 383);
            else if (k == 2) ay1 = 480 + $urandom_range(0, 31);
            issue(ax0, ay0, ax1, ay1, 3'($urandom_range(0, 7)));
            collect(1, 4 * w * h + 20);
            check_words("b2b");
            n_cmp++; if (done_c !== exp_q.size() + stalls) begin n_fail++; $display("FAIL b2b%0d_done_cycle got=%0d exp=%0d", n, done_c, exp_q.size() + stalls); end
            n_cmp++; if (err_at !== !exp_legal) begin n_fail++; $display("FAIL b2b%0d_err got=%b exp=%b", n, err_at, !exp_legal); end
            n_cmp++; if (we_full !== 0) begin n_fail++; $display("FAIL b2b%0d_we_while_full got=%0d exp=0", n, we_full); end
            n_cmp++; if (busy_low !== 0) begin n_fail++; $display("FAIL b2b%0d_busy_low got=%0d exp=0", n, busy_low); end
            n_cmp++; if (pix_count !== 19'(exp_q.size())) begin n_fail++; $display("FAIL b2b%0d_pix got=%0d exp=%0d", n, pix_count, exp_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_2x2();
        test_backpressure();
        test_single_and_row();
        test_illegal();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
